// File: rtl/vga_clken_gen.sv
// vga_clken_gen: multi-channel clock-enable strobe generator with lock tracking.
// Define VGA_CLKEN_SQUARE_EN to add the per-channel clk_sq square-wave export.
module vga_clken_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] en_out,
`ifdef VGA_CLKEN_SQUARE_EN
  output logic [NUM_CH-1:0] clk_sq,
`endif
  output logic              locked
);

  localparam int SC_W =
    (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int DEF_DIV =
    (DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV;

  typedef enum logic {
    SETTLE,
    LOCKED
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [SC_W-1:0] settle_cnt;
  logic [SC_W-1:0] settle_cnt_n;
  logic            cfg_hit;
  logic            run;

  logic [DIV_W-1:0] div_eff_w;
  logic [DIV_W-1:0] phase_eff_w;

  // Ratio 0 acts as 1; phase is clamped inside the period.
  assign div_eff_w = (cfg_div == '0) ?
                     DIV_W'(1) : cfg_div;
  assign phase_eff_w =
    (cfg_phase > (div_eff_w - 1'b1)) ?
    (div_eff_w - 1'b1) : cfg_phase;

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    cfg_ready    = 1'b0;
    cfg_hit      = 1'b0;
    unique case (state)
      SETTLE: begin
        if (settle_cnt == SC_W'(LOCK_CYCLES - 1)) begin
          state_n      = LOCKED;
          settle_cnt_n = '0;
        end else begin
          settle_cnt_n = settle_cnt + 1'b1;
        end
      end
      LOCKED: begin
        cfg_ready = 1'b1;
        cfg_hit   = cfg_valid &&
                    (32'(cfg_ch) < NUM_CH);
        if (cfg_hit) begin
          state_n      = SETTLE;
          settle_cnt_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      locked     <= (state_n == LOCKED);
    end
  end

  // Counters and strobes stop on the edge that leaves LOCKED,
  // so a reconfiguration never emits a runt strobe.
  assign run = (state == LOCKED) &&
               (state_n == LOCKED);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt;
    logic             en_q;
    logic             wr;

    assign wr = cfg_hit && (cfg_ch == CH_W'(i));

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        div_q   <= DIV_W'(DEF_DIV);
        phase_q <= '0;
        cnt     <= '0;
        en_q    <= 1'b0;
      end else begin
        if (wr) begin
          div_q   <= div_eff_w;
          phase_q <= phase_eff_w;
        end
        if (run) begin
          cnt <= (cnt == div_q - 1'b1) ?
                 '0 : cnt + 1'b1;
        end else begin
          cnt <= '0;
        end
        en_q <= run && (cnt == phase_q);
      end
    end

    assign en_out[i] = en_q;

`ifdef VGA_CLKEN_SQUARE_EN
    logic [DIV_W:0] half;
    logic           sq_q;

    assign half = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        sq_q <= 1'b0;
      end else begin
        sq_q <= run && ({1'b0, cnt} < half);
      end
    end

    assign clk_sq[i] = sq_q;
`endif
  end

endmodule

// File: tb/tb_vga_clken_gen.sv
// tb_vga_clken_gen: scoreboard bench for vga_clken_gen.
// Expected strobe patterns come from the period/phase formulas.
module tb_vga_clken_gen;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int LCK = 16;

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] sq;
  } exp_t;

  logic           refclk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [DW-1:0]  cfg_div = '0;
  logic [DW-1:0]  cfg_phase = '0;
  logic [NCH-1:0] en_out;
  logic [NCH-1:0] clk_sq;
  logic           locked;

`ifndef VGA_CLKEN_SQUARE_EN
  assign clk_sq = '0;
`endif

  vga_clken_gen #(
    .NUM_CH(NCH),
    .DIV_W(DW),
    .DEFAULT_DIV(2),
    .LOCK_CYCLES(LCK)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_phase(cfg_phase),
    .en_out(en_out),
`ifdef VGA_CLKEN_SQUARE_EN
    .clk_sq(clk_sq),
`endif
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  int   errs = 0;
  int   checks = 0;
  int   mdiv[NCH];
  int   mph[NCH];
  int   tpos = 0;
  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      mdiv[c] = 2;
      mph[c]  = 0;
    end
  endtask

  function automatic exp_t expect_at(int t);
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      int k;
      k = t - 1;
      if (t >= 1) begin
        if (k >= mph[c] && (k - mph[c]) % mdiv[c] == 0)
          e.en[c] = 1'b1;
`ifdef VGA_CLKEN_SQUARE_EN
        if (k % mdiv[c] < (mdiv[c] + 1) / 2)
          e.sq[c] = 1'b1;
`endif
      end
    end
    return e;
  endfunction

  task automatic wait_lock(string tag);
    int n;
    n = 0;
    while (!locked && n < 100) begin
      tick();
      n++;
      if (!locked)
        chk({tag, "_settle_out"}, {en_out, clk_sq}, 0);
    end
    chk({tag, "_lock_lat"}, n, LCK);
    chk({tag, "_ready"}, cfg_ready, 1);
    tpos = 0;
  endtask

  task automatic run_check(string tag, int m);
    exp_t e;
    for (int k = 0; k < m; k++)
      sb.push_back(expect_at(tpos + k));
    for (int k = 0; k < m; k++) begin
      e = sb.pop_front();
      chk($sformatf("%s_en[%0d]", tag, tpos + k),
          en_out, e.en);
      chk($sformatf("%s_sq[%0d]", tag, tpos + k),
          clk_sq, e.sq);
      tick();
    end
    tpos += m;
  endtask

  task automatic cfg(int ch, int dv, int ph);
    int d;
    cfg_ch    = 2'(ch);
    cfg_div   = DW'(dv);
    cfg_phase = DW'(ph);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    if (ch < NCH) begin
      d = (dv == 0) ? 1 : dv;
      mdiv[ch] = d;
      mph[ch]  = (ph > d - 1) ? d - 1 : ph;
    end
  endtask

  task automatic cfg_relock(string tag, int ch,
                            int dv, int ph, int m);
    cfg(ch, dv, ph);
    chk({tag, "_unlock"}, locked, 0);
    chk({tag, "_busy"}, cfg_ready, 0);
    chk({tag, "_en_clr"}, en_out, 0);
    wait_lock(tag);
    run_check(tag, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    #1 rst = 1'b1;
    #2;
    chk("rst_en", en_out, 0);
    chk("rst_lock", locked, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_sq", clk_sq, 0);
    #19 rst = 1'b0;

    wait_lock("t1");
    run_check("t1", 8);

    cfg_relock("t2", 0, 4, 3, 12);

    cfg_relock("t3a", 0, 0, 5, 6);
    cfg_relock("t3b", 0, 3, 7, 10);

    // Valid held across the whole settle window.
    cfg(2, 1, 0);
    chk("t4_unlock", locked, 0);
    cfg_ch    = 2'd1;
    cfg_div   = DW'(5);
    cfg_phase = DW'(1);
    cfg_valid = 1'b1;
    wait_lock("t4_hold");
    tick();
    cfg_valid = 1'b0;
    chk("t4_accept", locked, 0);
    mdiv[1] = 5;
    mph[1]  = 1;
    wait_lock("t4_relock");
    run_check("t4", 12);

    cfg(3, 7, 1);
    chk("t4_inv_lock", locked, 1);
    chk("t4_inv_ready", cfg_ready, 1);
    tpos++;
    run_check("t4_inv", 12);

    cfg(0, 2, 1);
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chk("t5a_lock", locked, 0);
    chk("t5a_ready", cfg_ready, 0);
    chk("t5a_en", en_out, 0);
    #2 rst = 1'b0;
    reset_model();
    wait_lock("t5a");
    run_check("t5a", 8);

    tick();
    chk("t5b_pre_en", en_out, 3'b111);
    #3 rst = 1'b1;
    #1;
    chk("t5b_lock", locked, 0);
    chk("t5b_ready", cfg_ready, 0);
    chk("t5b_en", en_out, 0);
    chk("t5b_sq", clk_sq, 0);
    #2 rst = 1'b0;
    reset_model();
    wait_lock("t5b");
    run_check("t5b", 8);

    cfg_relock("t6", 2, 5, 0, 15);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
